// File: rtl/mnist_pkg.sv
// Shared project constants for the MNIST datapath, plus the accumulator FSM encoding.
package mnist_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 8;
    localparam int LEN_W_DEF = 10;
    localparam int SHIFT_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN
    } acc_state_t;

endpackage

// File: rtl/qrequant.sv
// Combinational requantizer: bias add, round-half-up, arithmetic shift, saturate, optional ReLU.
module qrequant
    import mnist_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] bias,
    input  logic             relu_en,
    output logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] q
);

    localparam logic signed [ACC_W:0] ROUND   = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // NOTE: every branch below assigns q, so no latch is inferred.
    always_comb begin
        sum = acc + bias;
        // One extra bit keeps the rounding offset from wrapping near the positive limit.
        rounded = $signed({sum[ACC_W-1], sum}) + ROUND;
        shifted = rounded >>> SHIFT;
        if (relu_en && shifted[ACC_W])
            q = '0;
        else if (shifted > SAT_MAX)
            q = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN)
            q = SAT_MIN[OUT_W-1:0];
        else
            q = shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/qmult_accum.sv
// Dot-product accumulator: sums len products per job, then requantizes the biased sum once.
module qmult_accum
    import mnist_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] bias_din,
    input  logic             relu_en,
    input  logic [ACC_W-1:0] product_din,
    input  logic             product_din_vld,
    output logic             busy,
    output logic [ACC_W-1:0] acc_dout,
    output logic [OUT_W-1:0] dout,
    output logic             dout_vld
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] bias_q;
    logic             relu_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             last_product;
    logic [ACC_W-1:0] sum;
    logic [OUT_W-1:0] q;

    // cnt counts accepted products; the job ends when it reaches the latched length.
    assign last_product = (cnt + LEN_W'(1)) == len_q;

    qrequant #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
    ) u_qrequant (
        .acc    (acc),
        .bias   (bias_q),
        .relu_en(relu_q),
        .sum    (sum),
        .q      (q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            busy     <= 1'b0;
            acc_dout <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (ce) begin
            dout_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        bias_q <= bias_din;
                        relu_q <= relu_en;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= (len == '0) ? FIN : ACC;
                    end
                end
                ACC: begin
                    if (product_din_vld) begin
                        acc <= acc + product_din;
                        cnt <= cnt + LEN_W'(1);
                        if (last_product)
                            state <= FIN;
                    end
                end
                FIN: begin
                    acc_dout <= sum;
                    dout     <= q;
                    dout_vld <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_accum.sv
// Self-checking bench for qmult_accum: directed vector table, hand-written corner sequences, random jobs.
`timescale 1ns/1ps
module tb_qmult_accum;

    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int LEN_W = 10;
    localparam int SHIFT = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] bias_din;
    logic             relu_en;
    logic [ACC_W-1:0] product_din;
    logic             product_din_vld;
    logic             busy;
    logic [ACC_W-1:0] acc_dout;
    logic [OUT_W-1:0] dout;
    logic             dout_vld;

    int n_vec = 0;
    int n_bad = 0;
    int prod_q[$];

    typedef struct {
        int len;
        int bias;
        bit relu;
        int p[4];
        int gap;
        int exp_acc;
        int exp_dout;
    } vec_t;

    vec_t vecs[10];

    qmult_accum dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .start          (start),
        .len            (len),
        .bias_din       (bias_din),
        .relu_en        (relu_en),
        .product_din    (product_din),
        .product_din_vld(product_din_vld),
        .busy           (busy),
        .acc_dout       (acc_dout),
        .dout           (dout),
        .dout_vld       (dout_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the job's products, independent of any FSM.
    function automatic void model(input int bias, input bit relu,
                                  output logic [31:0] e_acc, output logic [7:0] e_q);
        longint total = longint'(bias);
        int     wrapped;
        longint r;
        foreach (prod_q[i]) total += longint'(prod_q[i]);
        wrapped = int'(total);
        r = (longint'(wrapped) + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (r > longint'(2 ** (OUT_W - 1) - 1)) r = longint'(2 ** (OUT_W - 1) - 1);
        if (r < -longint'(2 ** (OUT_W - 1)))    r = -longint'(2 ** (OUT_W - 1));
        if (relu && r < 0) r = 0;
        e_acc = wrapped;
        e_q   = r[7:0];
    endfunction

    // Drives one complete job from IDLE and checks exact result latency and values.
    task automatic run_job(input string name, input int bias, input bit relu, input int gap,
                           input bit use_exp, input int exp_acc, input int exp_dout);
        logic [31:0] e_acc;
        logic [7:0]  e_q;
        model(bias, relu, e_acc, e_q);
        if (use_exp) begin
            e_acc = exp_acc;
            e_q   = exp_dout[7:0];
        end
        start    = 1'b1;
        len      = LEN_W'(prod_q.size());
        bias_din = bias;
        relu_en  = relu;
        tick();
        start = 1'b0;
        check({name, "/busy"}, 32'(busy), 32'd1);
        foreach (prod_q[i]) begin
            repeat (gap) tick();
            product_din     = prod_q[i];
            product_din_vld = 1'b1;
            tick();
            product_din_vld = 1'b0;
        end
        check({name, "/vld_early"}, 32'(dout_vld), 32'd0);
        tick();
        check({name, "/vld"}, 32'(dout_vld), 32'd1);
        check({name, "/acc"}, acc_dout, e_acc);
        check({name, "/dout"}, 32'(dout), 32'(e_q));
        tick();
        check({name, "/vld_pulse"}, 32'(dout_vld), 32'd0);
        check({name, "/idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;

        vecs[0] = '{3, 6, 1'b0, '{100, 200, -50, 0}, 0, 256, 2};
        vecs[1] = '{2, 0, 1'b0, '{20000, 20000, 0, 0}, 0, 40000, 127};
        vecs[2] = '{2, 0, 1'b0, '{-20000, -20000, 0, 0}, 0, -40000, -128};
        vecs[3] = '{2, 0, 1'b1, '{-20000, -20000, 0, 0}, 1, -40000, 0};
        vecs[4] = '{0, 640, 1'b0, '{0, 0, 0, 0}, 0, 640, 5};
        vecs[5] = '{1, 0, 1'b0, '{63, 0, 0, 0}, 1, 63, 0};
        vecs[6] = '{1, 0, 1'b0, '{64, 0, 0, 0}, 0, 64, 1};
        vecs[7] = '{1, 0, 1'b0, '{-65, 0, 0, 0}, 2, -65, -1};
        vecs[8] = '{1, 32'h7FFF_FFF0, 1'b0, '{15, 0, 0, 0}, 0, 32'h7FFF_FFFF, 127};
        vecs[9] = '{1, 10, 1'b1, '{300, 0, 0, 0}, 0, 310, 2};

        rst = 1'b1; ce = 1'b1; start = 1'b0; len = '0; bias_din = '0;
        relu_en = 1'b0; product_din = '0; product_din_vld = 1'b0;
        repeat (3) tick();
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/dout", 32'(dout), 32'd0);
        check("reset/acc", acc_dout, 32'd0);
        check("reset/vld", 32'(dout_vld), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            prod_q.delete();
            for (int k = 0; k < vecs[v].len; k++) prod_q.push_back(vecs[v].p[k]);
            run_job($sformatf("vec%0d", v), vecs[v].bias, vecs[v].relu, vecs[v].gap,
                    1'b1, vecs[v].exp_acc, vecs[v].exp_dout);
        end

        // Extras: product during start, ce-low stall, extra start mid-job, product during FIN.
        start = 1'b1; len = LEN_W'(4); bias_din = '0; relu_en = 1'b0;
        product_din = 777; product_din_vld = 1'b1;
        tick();
        start = 1'b0;
        product_din = 10;
        tick();
        product_din_vld = 1'b0;
        tick();
        ce = 1'b0; product_din = 999; product_din_vld = 1'b1;
        tick();
        ce = 1'b1; product_din_vld = 1'b0;
        start = 1'b1; len = LEN_W'(1);
        tick();
        start = 1'b0;
        product_din = 20; product_din_vld = 1'b1;
        tick();
        product_din = 30; ce = 1'b0;
        tick();
        ce = 1'b1;
        tick();
        product_din = 40;
        tick();
        check("extra/vld_early", 32'(dout_vld), 32'd0);
        product_din = 5555;
        tick();
        product_din_vld = 1'b0;
        check("extra/vld", 32'(dout_vld), 32'd1);
        check("extra/acc", acc_dout, 32'd100);
        check("extra/dout", 32'(dout), 32'd1);
        ce = 1'b0;
        tick();
        check("extra/ce_hold", 32'(dout_vld), 32'd1);
        ce = 1'b1;
        tick();
        check("extra/vld_pulse", 32'(dout_vld), 32'd0);
        check("extra/idle", 32'(busy), 32'd0);

        // Reset in the middle of a job discards it.
        start = 1'b1; len = LEN_W'(4); bias_din = 1000;
        tick();
        start = 1'b0;
        product_din = 1; product_din_vld = 1'b1;
        tick();
        product_din = 2;
        tick();
        product_din_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/dout", 32'(dout), 32'd0);
        check("rst/acc", acc_dout, 32'd0);
        check("rst/vld", 32'(dout_vld), 32'd0);
        seen = 0;
        product_din = 3; product_din_vld = 1'b1;
        repeat (6) begin
            tick();
            if (dout_vld) seen++;
        end
        product_din_vld = 1'b0;
        check("rst/no_vld", 32'(seen), 32'd0);
        prod_q = '{5, 6, 7};
        run_job("rst/next", 100, 1'b0, 0, 1'b1, 118, 1);

        // Back-to-back: second start lands in the first job's dout_vld cycle.
        start = 1'b1; len = LEN_W'(1); bias_din = '0; relu_en = 1'b0;
        tick();
        start = 1'b0;
        product_din = 300; product_din_vld = 1'b1;
        tick();
        product_din_vld = 1'b0;
        tick();
        start = 1'b1; len = LEN_W'(2); bias_din = -200;
        check("b2b/a_vld", 32'(dout_vld), 32'd1);
        check("b2b/a_acc", acc_dout, 32'd300);
        check("b2b/a_dout", 32'(dout), 32'd2);
        tick();
        start = 1'b0;
        check("b2b/b_busy", 32'(busy), 32'd1);
        product_din = -100; product_din_vld = 1'b1;
        tick();
        tick();
        product_din_vld = 1'b0;
        tick();
        check("b2b/b_vld", 32'(dout_vld), 32'd1);
        check("b2b/b_acc", acc_dout, 32'hFFFF_FE70);
        check("b2b/b_dout", 32'(dout), 32'h0000_00FD);
        tick();

        // Random jobs against the arithmetic model.
        for (int j = 0; j < 25; j++) begin
            int n;
            int b;
            prod_q.delete();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) prod_q.push_back(int'($urandom));
                else prod_q.push_back(int'($urandom_range(0, 40000)) - 20000);
            end
            b = ($urandom_range(0, 4) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            run_job($sformatf("rnd%0d", j), b, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
